// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encodings for the sequential divider and the hazard unit
package seq_divider_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift {rem,q} left, trial subtract, restore on borrow
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  // rem < divisor keeps shifted below 2*divisor, so bit WIDTH of the difference is a true borrow
  always_comb begin
    shifted = {rem_in, q_in[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    borrow  = trial[WIDTH];
    rem_out = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_out   = {q_in[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed/unsigned restoring divider, one quotient bit per clock
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import seq_divider_pkg::*;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] step_rem, step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .q_in    (acc_q),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  assign sign_a = is_signed & dividend[WIDTH-1];
  assign sign_b = is_signed & divisor[WIDTH-1];

  // acc_q holds the dividend magnitude and fills with quotient bits as it shifts out
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    dvsr_d      = dvsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end else begin
            rem_d   = '0;
            acc_d   = sign_a ? -dividend : dividend;
            dvsr_d  = sign_b ? -divisor : divisor;
            q_neg_d = sign_a ^ sign_b;
            r_neg_d = sign_a;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        acc_d = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        quotient_d  = q_neg_q ? -acc_q : acc_q;
        remainder_d = r_neg_q ? -rem_q : rem_q;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      dvsr_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      dvsr_q      <= dvsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and randomized checks of seq_divider against an arithmetic model
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int tests;
  int fails;

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, remainder takes dividend sign
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit glitch, input string tag);
    logic [31:0] eq, er;
    logic        ez;
    int          n, busy_n;
    model(a, b, s, eq, er, ez);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n      = 1;
    busy_n = 0;
    while (!done && n < 100) begin
      if (busy) busy_n++;
      if (glitch && n == 5) begin
        start     = 1'b1;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = ~s;
      end
      if (glitch && n == 6) start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), (b == 32'd0) ? 32'd1 : 32'd34);
    chk({tag, "_busy_cycles"}, 32'(busy_n), (b == 32'd0) ? 32'd0 : 32'd33);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_q_held"}, quotient, eq);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          mode;
    int          seen_done;
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, 1'b0, "u100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "s_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, "s_7_m2");
    run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b0, "s_m7_m2");
    run_div(32'h0000_1234, 32'd0, 1'b0, 1'b0, "div0");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_min_m1");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "u_max_1");
    run_div(32'd123456, 32'd789, 1'b0, 1'b1, "restart_ignored");

    @(negedge clk);
    dividend  = 32'd5000;
    divisor   = 32'd3;
    is_signed = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    seen_done = 0;
    repeat (40) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    run_div(32'd5000, 32'd3, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 30; i++) begin
      ra   = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       begin rb = $urandom; ra = 32'h8000_0000; end
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_div(ra, rb, rs, 1'b0, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
